// File: rtl/seq_detector_param.sv
// Serial pattern detector: PAT_W-bit history, FILL/ARMED FSM, registered match pulse.
// Optional saturating match counter enabled by defining SEQ_DETECTOR_CNT_EN.
module seq_detector_param #(
    parameter int unsigned      PAT_W = 3,
    parameter logic [PAT_W-1:0] PAT   = 3'b010,
    parameter int unsigned      CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             in_valid,
    input  logic             overlap_en,
    input  logic             clr_cnt,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    typedef enum logic {
        ST_FILL,
        ST_ARMED
    } state_t;

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               match_q;
    logic [PAT_W-1:0]   shifted;
    logic               hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            match_q <= hit;
        end
    end

    // ARMED already implies fill==PAT_W, so only the last fill step needs the count.
    always_comb begin
        shifted = {hist_q[PAT_W-2:0], ser_in};
        hit     = in_valid
                  && ((state_q == ST_ARMED) || (fill_q == FILL_LAST))
                  && (shifted == PAT);
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        if (in_valid) begin
            hist_d = shifted;
            if (hit && !overlap_en) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FILL_W'(1'b1);
            end
            state_d = (fill_d == FILL_FULL) ? ST_ARMED : ST_FILL;
        end
    end

    assign match = match_q;

`ifdef SEQ_DETECTOR_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Clear wins over a coincident match; the match pulse itself is unaffected.
    always_ff @(posedge clk) begin
        if (rst || clr_cnt) begin
            cnt_q <= '0;
        end else if (hit && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1'b1);
        end
    end

    assign match_cnt = cnt_q;
    assign cnt_sat   = (cnt_q == '1);
`else
    logic unused_clr_cnt;
    assign unused_clr_cnt = clr_cnt;
    assign match_cnt      = '0;
    assign cnt_sat        = 1'b0;
`endif

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 The block SHALL have the parameter PAT_W, default 3, meaning pattern length in bits; legal range 2..16.
REQ-002 The block SHALL have the parameter PAT, default 3'b010, meaning the PAT_W-bit target pattern, MSB received first.
REQ-003 The block SHALL have the parameter CNT_W, default 8, meaning match counter width; legal range 2..16.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all logic acts on its rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have the port ser_in, input, 1 bit: serial data bit.
REQ-007 The block SHALL have the port in_valid, input, 1 bit: ser_in is sampled only when high.
REQ-008 The block SHALL have the port overlap_en, input, 1 bit: 1 selects overlapping detection, 0 selects non-overlapping detection.
REQ-009 The block SHALL have the port clr_cnt, input, 1 bit: synchronous clear of the match counter.
REQ-010 The block SHALL have the port match, output, 1 bit: registered one-cycle pulse per detected pattern.
REQ-011 The block SHALL have the port match_cnt, output, CNT_W bits: saturating count of matches.
REQ-012 The block SHALL have the port cnt_sat, output, 1 bit: high while match_cnt equals 2^CNT_W-1.

Function
REQ-013 The block SHALL keep a PAT_W-bit history register hist and a fill counter fill (0..PAT_W), and SHALL run an FSM with states FILL (fill<PAT_W) and ARMED (fill==PAT_W).
REQ-014 On an edge with in_valid=1, the block SHALL update hist to {hist[PAT_W-2:0], ser_in} and SHALL increment fill, saturating at PAT_W.
REQ-015 The match condition SHALL be: in_valid=1, fill>=PAT_W-1, and {hist[PAT_W-2:0], ser_in}==PAT.
REQ-016 match SHALL be registered, going high for exactly the one cycle after the edge that accepted the final pattern bit; latency is 1 cycle.
REQ-017 On an edge with in_valid=0, the block SHALL hold hist, fill and the FSM state, SHALL drive match to 0, and SHALL treat the gap as transparent (bits either side of the gap combine).
REQ-018 With overlap_en=1, the block SHALL leave fill at PAT_W after a match, so a suffix of the pattern can start the next match.
REQ-019 With overlap_en=0, the block SHALL set fill to 0 and the FSM to FILL on a match, so no bit is reused.
REQ-020 overlap_en SHALL be sampled every edge, and a change SHALL affect only subsequent matches.
REQ-021 On each match pulse, match_cnt SHALL increment by 1, saturating at 2^CNT_W-1; cnt_sat SHALL be combinational from match_cnt.
REQ-022 clr_cnt=1 SHALL set match_cnt to 0 at the next edge; if a match occurs on the same edge, clr_cnt SHALL take priority (count 0) and the match pulse SHALL still be asserted.
REQ-023 clr_cnt SHALL NOT affect hist, fill, the FSM state or match.

Reset
REQ-024 When rst=1 at a rising edge, the block SHALL set hist=0, fill=0, FSM=FILL, match=0, match_cnt=0 and cnt_sat=0; rst SHALL override all other inputs.
REQ-025 A reset mid-pattern SHALL discard all partial history, and detection SHALL restart from an empty history.

Configuration
REQ-026 When the macro SEQ_DETECTOR_CNT_EN is defined, the block SHALL implement match_cnt, cnt_sat and clr_cnt as specified.
REQ-027 When SEQ_DETECTOR_CNT_EN is undefined, the block SHALL tie match_cnt to 0 and cnt_sat to 0, SHALL ignore clr_cnt, SHALL keep the ports present, and detection SHALL be unchanged.

Verification
REQ-028 Overlap test: PAT=010, overlap_en=1, stream 0,1,0,1,0 (in_valid=1) -> match pulses after bits 3 and 5; match_cnt=2.
REQ-029 Non-overlap test: same stream with overlap_en=0 -> a single match after bit 3; match_cnt=1.
REQ-030 Gap test: stream 0, gap of 3 idle cycles, 1, gap, 0 -> one match, 1 cycle after the final 0 is accepted; match=0 throughout the gaps.
REQ-031 Reset mid-pattern: 0,1, then rst for 1 cycle, then 0 -> no match; then 1,0 -> match after the final 0.
REQ-032 Saturation with CNT_W=2: 5 matches -> match_cnt=3 and cnt_sat=1; clr_cnt on the same edge as a 6th match -> match_cnt=0 and match pulse=1.
REQ-033 Width test with PAT_W=4, PAT=4'b1101, overlap_en=1: stream 1,1,0,1,1,0,1 -> matches after bits 4 and 7.
